// File: rtl/delay_sum_beamformer_if.sv
// Interface bundling the beamformer's sample/steering inputs and its audio,
// strobe and debug outputs. The master side is the capture front end that
// drives samples; the slave side is the beamformer.
//
// Handshake: every *valid* signal here is a one-cycle strobe with no ready
// and no backpressure. valid_in[n] qualifies sample_in_n for exactly the
// cycle it is high; valid_out qualifies audio_out for exactly one cycle.
interface delay_sum_beamformer_if #(
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic signed [15:0] sample_in_0;
  logic signed [15:0] sample_in_1;
  logic signed [15:0] sample_in_2;
  logic [2:0]         valid_in;
  logic [AW-1:0]      delay_in_0;
  logic [AW-1:0]      delay_in_1;
  logic [AW-1:0]      delay_in_2;
  logic [2:0]         ch_en_in;
  logic signed [15:0] audio_out;
  logic               valid_out;
  logic               timeout_out;
  logic               overrun_out;
  logic [2:0]         state_dbg;

  modport master (
    output sample_in_0, sample_in_1, sample_in_2, valid_in,
    output delay_in_0, delay_in_1, delay_in_2, ch_en_in,
    input  audio_out, valid_out, timeout_out, overrun_out, state_dbg
  );

  modport slave (
    input  sample_in_0, sample_in_1, sample_in_2, valid_in,
    input  delay_in_0, delay_in_1, delay_in_2, ch_en_in,
    output audio_out, valid_out, timeout_out, overrun_out, state_dbg
  );
endinterface

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer for a three-mic array. Per-channel samples are
// grouped into frames, written into a circular history per channel, and the
// delay-steered taps are summed, shifted and saturated to a mono output.
// The output registers are loaded on the edge that enters DONE, so valid_out
// is high during DONE, five cycles after the frame became complete.
module delay_sum_beamformer #(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 256,
  parameter int SHIFT   = 1
) (
  input logic               clk_in,
  input logic               rst_in,
  delay_sum_beamformer_if.slave bf
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_COLLECT = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_ACC0    = 3'd2;
  localparam logic [2:0] S_ACC1    = 3'd3;
  localparam logic [2:0] S_ACC2    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic signed [17:0] SAT_MAX = 18'sd32767;
  localparam logic signed [17:0] SAT_MIN = -18'sd32768;

  logic [2:0]         r_state;
  logic [2:0]         r_pend;
  logic signed [15:0] r_pend_data [0:2];
  logic signed [15:0] r_last      [0:2];
  logic signed [15:0] r_hist      [0:2][0:DEPTH-1];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_delay     [0:2];
  logic [2:0]         r_ch_en;
  logic signed [17:0] r_acc;
  logic [TW-1:0]      r_tcnt;
  logic               r_forced;
  logic signed [15:0] r_audio;
  logic               r_valid;
  logic               r_timeout;
  logic               r_overrun;

  logic signed [15:0] w_sample    [0:2];
  logic [AW-1:0]      w_delay_in  [0:2];
  logic signed [15:0] w_snap      [0:2];
  logic [1:0]         w_idx;
  logic [AW-1:0]      w_raddr;
  logic signed [15:0] w_rdata;
  logic signed [17:0] w_term;
  logic signed [17:0] w_acc_sum;
  logic signed [17:0] w_shifted;
  logic signed [15:0] w_sat;
  logic               w_overrun;

  assign w_sample[0]   = bf.sample_in_0;
  assign w_sample[1]   = bf.sample_in_1;
  assign w_sample[2]   = bf.sample_in_2;
  assign w_delay_in[0] = bf.delay_in_0;
  assign w_delay_in[1] = bf.delay_in_1;
  assign w_delay_in[2] = bf.delay_in_2;

  // Frame snapshot: a pending channel contributes its new sample, a silent one repeats its last
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      w_snap[n] = r_pend[n] ? r_pend_data[n] : r_last[n];
    end
  end

  // Tap selection and accumulate/shift/saturate path for the current ACC step
  always_comb begin
    w_idx = 2'd2;
    if (r_state == S_ACC0) w_idx = 2'd0;
    else if (r_state == S_ACC1) w_idx = 2'd1;
    w_raddr   = r_wptr - r_delay[w_idx];
    w_rdata   = r_hist[w_idx][w_raddr];
    w_term    = r_ch_en[w_idx] ? {{2{w_rdata[15]}}, w_rdata} : 18'sd0;
    w_acc_sum = r_acc + w_term;
    w_shifted = w_acc_sum >>> SHIFT;
    if (w_shifted > SAT_MAX)      w_sat = 16'sh7FFF;
    else if (w_shifted < SAT_MIN) w_sat = 16'sh8000;
    else                          w_sat = w_shifted[15:0];
  end

  // A consumed pending bit in WRITE is not an overrun: its data is taken this cycle
  assign w_overrun = (r_state != S_WRITE) && (|(bf.valid_in & r_pend));

  // Capture strobed samples in every state; WRITE consumes all pending bits
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pend    <= '0;
      r_overrun <= 1'b0;
      for (int n = 0; n < 3; n++) r_pend_data[n] <= '0;
    end else begin
      r_overrun <= w_overrun;
      if (r_state == S_WRITE) r_pend <= bf.valid_in;
      else                    r_pend <= r_pend | bf.valid_in;
      for (int n = 0; n < 3; n++) begin
        if (bf.valid_in[n]) r_pend_data[n] <= w_sample[n];
      end
    end
  end

  // Frame FSM: collect, write history, accumulate three taps, publish
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_COLLECT;
      r_wptr    <= '0;
      r_ch_en   <= '0;
      r_acc     <= '0;
      r_tcnt    <= '0;
      r_forced  <= 1'b0;
      r_audio   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        r_last[c]  <= '0;
        r_delay[c] <= '0;
        for (int a = 0; a < DEPTH; a++) r_hist[c][a] <= '0;
      end
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (r_pend == 3'b111) begin
            r_forced <= 1'b0;
            r_state  <= S_WRITE;
          end else if (|r_pend) begin
            if (r_tcnt == TW'(TIMEOUT - 1)) begin
              r_forced <= 1'b1;
              r_state  <= S_WRITE;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end else begin
            r_tcnt <= '0;
          end
        end
        S_WRITE: begin
          for (int c = 0; c < 3; c++) begin
            r_hist[c][r_wptr] <= w_snap[c];
            r_last[c]         <= w_snap[c];
            r_delay[c]        <= w_delay_in[c];
          end
          r_ch_en <= bf.ch_en_in;
          r_acc   <= '0;
          r_tcnt  <= '0;
          r_state <= S_ACC0;
        end
        S_ACC0: begin
          r_acc   <= w_acc_sum;
          r_state <= S_ACC1;
        end
        S_ACC1: begin
          r_acc   <= w_acc_sum;
          r_state <= S_ACC2;
        end
        S_ACC2: begin
          r_acc     <= w_acc_sum;
          r_audio   <= w_sat;
          r_valid   <= 1'b1;
          r_timeout <= r_forced;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_wptr  <= r_wptr + AW'(1);
          r_state <= S_COLLECT;
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

  assign bf.audio_out   = r_audio;
  assign bf.valid_out   = r_valid;
  assign bf.timeout_out = r_timeout;
  assign bf.overrun_out = r_overrun;
  assign bf.state_dbg   = r_state;
endmodule
